// File: rtl/wb_ctrl.sv
// Writeback controller: merges the ALU writeback and buffered LSU load results onto
// the single register-file write port, and generates fetch redirects or misaligned-target exceptions.
module wb_ctrl #(
   parameter int XLEN     = 32,
   parameter int LQ_DEPTH = 4,
   localparam int PW      = $clog2(LQ_DEPTH),
   localparam int CW      = PW + 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] alu_wb_data,
   input  logic [4:0]      alu_wb_rd_addr,
   input  logic            alu_wb_rd_wr_en,
   input  logic [XLEN-1:0] alu_pc_out,
   input  logic            alu_pc_load,
   input  logic            lsu_wb_valid,
   output logic            lsu_wb_ready,
   input  logic [XLEN-1:0] lsu_wb_data,
   input  logic [4:0]      lsu_wb_rd_addr,
   output logic            rf_wr_en,
   output logic [4:0]      rf_wr_addr,
   output logic [XLEN-1:0] rf_wr_data,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            exc_misalign,
   output logic [XLEN-1:0] exc_tval,
   output logic [CW-1:0]   lq_count
);

   logic [XLEN-1:0]     q_data [LQ_DEPTH];
   logic [4:0]          q_rd   [LQ_DEPTH];
   logic [LQ_DEPTH-1:0] q_kill;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic                alu_eff;
   logic                push;
   logic                enq;
   logic                pop;

   assign lsu_wb_ready = rst_n & (lq_count != CW'(LQ_DEPTH));

   always_comb begin
      alu_eff = alu_wb_rd_wr_en & (alu_wb_rd_addr != 5'd0);
      push    = lsu_wb_valid & lsu_wb_ready;
      enq     = push & (lsu_wb_rd_addr != 5'd0);
      pop     = ~alu_eff & (lq_count != '0);
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         q_data[wr_ptr] <= lsu_wb_data;
         q_rd[wr_ptr]   <= lsu_wb_rd_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         lq_count       <= '0;
         q_kill         <= '0;
         rf_wr_en       <= 1'b0;
         rf_wr_addr     <= '0;
         rf_wr_data     <= '0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         exc_misalign   <= 1'b0;
         exc_tval       <= '0;
      end else begin
         // Stale slots may also get killed; harmless, since enqueue clears the bit and wins here.
         if (alu_eff) begin
            for (int unsigned i = 0; i < LQ_DEPTH; i++) begin
               if (q_rd[i] == alu_wb_rd_addr) q_kill[i] <= 1'b1;
            end
         end
         if (enq) begin
            q_kill[wr_ptr] <= 1'b0;
            wr_ptr         <= wr_ptr + PW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         lq_count <= lq_count + CW'(enq) - CW'(pop);

         if (alu_eff) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= alu_wb_rd_addr;
            rf_wr_data <= alu_wb_data;
         end else if (pop && !q_kill[rd_ptr]) begin
            rf_wr_en   <= 1'b1;
            rf_wr_addr <= q_rd[rd_ptr];
            rf_wr_data <= q_data[rd_ptr];
         end else begin
            rf_wr_en <= 1'b0;
         end

         redirect_valid <= alu_pc_load & (alu_pc_out[1:0] == 2'b00);
         exc_misalign   <= alu_pc_load & (alu_pc_out[1:0] != 2'b00);
         if (alu_pc_load && alu_pc_out[1:0] == 2'b00) redirect_pc <= alu_pc_out;
         if (alu_pc_load && alu_pc_out[1:0] != 2'b00) exc_tval <= alu_pc_out;
      end
   end

endmodule

// File: tb/tb_wb_ctrl.sv
// Directed self-checking bench for wb_ctrl with LQ_DEPTH=4.
module tb_wb_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu_wb_data;
   logic [4:0]  alu_wb_rd_addr;
   logic        alu_wb_rd_wr_en;
   logic [31:0] alu_pc_out;
   logic        alu_pc_load;
   logic        lsu_wb_valid;
   logic        lsu_wb_ready;
   logic [31:0] lsu_wb_data;
   logic [4:0]  lsu_wb_rd_addr;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        exc_misalign;
   logic [31:0] exc_tval;
   logic [2:0]  lq_count;

   int n_checks = 0;
   int n_fail   = 0;

   wb_ctrl #(.XLEN(32), .LQ_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_wb_data(alu_wb_data), .alu_wb_rd_addr(alu_wb_rd_addr), .alu_wb_rd_wr_en(alu_wb_rd_wr_en),
      .alu_pc_out(alu_pc_out), .alu_pc_load(alu_pc_load),
      .lsu_wb_valid(lsu_wb_valid), .lsu_wb_ready(lsu_wb_ready),
      .lsu_wb_data(lsu_wb_data), .lsu_wb_rd_addr(lsu_wb_rd_addr),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .exc_misalign(exc_misalign), .exc_tval(exc_tval), .lq_count(lq_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      alu_wb_rd_wr_en = 1'b0; alu_wb_rd_addr = '0; alu_wb_data = '0;
      alu_pc_load = 1'b0; alu_pc_out = '0;
      lsu_wb_valid = 1'b0; lsu_wb_rd_addr = '0; lsu_wb_data = '0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle_inputs();
      tick(); tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wr_en got %b exp 0", rf_wr_en); end
      n_checks++; if (rf_wr_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_wr_addr got %0d exp 0", rf_wr_addr); end
      n_checks++; if (rf_wr_data !== 32'd0) begin n_fail++; $display("FAIL reset_rf_wr_data got %h exp 0", rf_wr_data); end
      n_checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin n_fail++; $display("FAIL reset_redirect got %b/%h exp 0/0", redirect_valid, redirect_pc); end
      n_checks++; if (exc_misalign !== 1'b0 || exc_tval !== 32'd0) begin n_fail++; $display("FAIL reset_exc got %b/%h exp 0/0", exc_misalign, exc_tval); end
      n_checks++; if (lq_count !== 3'd0) begin n_fail++; $display("FAIL reset_lq_count got %0d exp 0", lq_count); end
      n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got %b exp 0", lsu_wb_ready); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release got %b exp 1", lsu_wb_ready); end
   endtask

   task automatic test_alu;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd5; alu_wb_data = 32'hDEADBEEF;
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL alu_write got %b/%0d/%h exp 1/5/deadbeef", rf_wr_en, rf_wr_addr, rf_wr_data); end
      alu_wb_rd_addr = 5'd0; alu_wb_data = 32'h12345678;
      tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL alu_rd0 got %b exp 0", rf_wr_en); end
      idle_inputs();
      tick();
   endtask

   task automatic test_fill_drain;
      logic [4:0] rds [4];
      rds[0] = 5'd2; rds[1] = 5'd3; rds[2] = 5'd4; rds[3] = 5'd6;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'hA1;
      for (int k = 0; k < 4; k++) begin
         lsu_wb_valid = 1'b1; lsu_wb_rd_addr = rds[k]; lsu_wb_data = 32'h100 + k;
         #1;
         n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b exp 1", k, lsu_wb_ready); end
         tick();
         n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd1 || rf_wr_data !== 32'hA1) begin
            n_fail++; $display("FAIL fill_alu[%0d] got %b/%0d/%h exp 1/1/a1", k, rf_wr_en, rf_wr_addr, rf_wr_data); end
      end
      n_checks++; if (lq_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got %0d exp 4", lq_count); end
      n_checks++; if (lsu_wb_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready got %b exp 0", lsu_wb_ready); end
      idle_inputs();
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== rds[k] || rf_wr_data !== 32'h100 + k) begin
            n_fail++; $display("FAIL drain[%0d] got %b/%0d/%h exp 1/%0d/%h", k, rf_wr_en, rf_wr_addr, rf_wr_data, rds[k], 32'h100 + k); end
         n_checks++; if (lq_count !== 3'(3 - k)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d exp %0d", k, lq_count, 3 - k); end
         n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready[%0d] got %b exp 1", k, lsu_wb_ready); end
      end
      tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL drain_empty got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_waw_squash;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd9; alu_wb_data = 32'h55;
      lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd7; lsu_wb_data = 32'h11;
      tick();
      lsu_wb_valid = 1'b0;
      alu_wb_rd_addr = 5'd7; alu_wb_data = 32'h22;
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h22) begin
         n_fail++; $display("FAIL waw_alu got %b/%0d/%h exp 1/7/22", rf_wr_en, rf_wr_addr, rf_wr_data); end
      n_checks++; if (lq_count !== 3'd1) begin n_fail++; $display("FAIL waw_count_held got %0d exp 1", lq_count); end
      idle_inputs();
      tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL waw_killed_pop got en %b addr %0d data %h exp en 0", rf_wr_en, rf_wr_addr, rf_wr_data); end
      n_checks++; if (lq_count !== 3'd0) begin n_fail++; $display("FAIL waw_count_popped got %0d exp 0", lq_count); end
      tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL waw_after got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_same_cycle_kill;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd8; alu_wb_data = 32'h44;
      lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd8; lsu_wb_data = 32'h33;
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd8 || rf_wr_data !== 32'h44) begin
         n_fail++; $display("FAIL same_alu got %b/%0d/%h exp 1/8/44", rf_wr_en, rf_wr_addr, rf_wr_data); end
      idle_inputs();
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd8 || rf_wr_data !== 32'h33) begin
         n_fail++; $display("FAIL same_load got %b/%0d/%h exp 1/8/33", rf_wr_en, rf_wr_addr, rf_wr_data); end
      n_checks++; if (lq_count !== 3'd0) begin n_fail++; $display("FAIL same_count got %0d exp 0", lq_count); end
   endtask

   task automatic test_rd0_push;
      lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd0; lsu_wb_data = 32'h77;
      #1;
      n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_ready got %b exp 1", lsu_wb_ready); end
      tick();
      idle_inputs();
      n_checks++; if (lq_count !== 3'd0) begin n_fail++; $display("FAIL rd0_count got %0d exp 0", lq_count); end
      tick();
      n_checks++; if (rf_wr_en !== 1'b0) begin n_fail++; $display("FAIL rd0_no_write got %b exp 0", rf_wr_en); end
   endtask

   task automatic test_push_pop;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'h1;
      lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'd10; lsu_wb_data = 32'hA0;
      tick();
      alu_wb_rd_wr_en = 1'b0;
      lsu_wb_rd_addr = 5'd11; lsu_wb_data = 32'hB0;
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd10 || rf_wr_data !== 32'hA0) begin
         n_fail++; $display("FAIL pp_head got %b/%0d/%h exp 1/10/a0", rf_wr_en, rf_wr_addr, rf_wr_data); end
      n_checks++; if (lq_count !== 3'd1) begin n_fail++; $display("FAIL pp_count got %0d exp 1", lq_count); end
      idle_inputs();
      tick();
      n_checks++; if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd11 || rf_wr_data !== 32'hB0) begin
         n_fail++; $display("FAIL pp_next got %b/%0d/%h exp 1/11/b0", rf_wr_en, rf_wr_addr, rf_wr_data); end
      tick();
   endtask

   task automatic test_redirect;
      alu_pc_load = 1'b1; alu_pc_out = 32'h1000;
      tick();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1000 || exc_misalign !== 1'b0) begin
         n_fail++; $display("FAIL redir_a got %b/%h exc %b exp 1/1000 exc 0", redirect_valid, redirect_pc, exc_misalign); end
      alu_pc_out = 32'h2004;
      tick();
      n_checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2004) begin
         n_fail++; $display("FAIL redir_b2b got %b/%h exp 1/2004", redirect_valid, redirect_pc); end
      alu_pc_out = 32'h1002;
      tick();
      n_checks++; if (exc_misalign !== 1'b1 || exc_tval !== 32'h1002 || redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL misalign got %b/%h redir %b exp 1/1002 redir 0", exc_misalign, exc_tval, redirect_valid); end
      alu_pc_load = 1'b0;
      tick();
      n_checks++; if (exc_misalign !== 1'b0 || redirect_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_idle got exc %b redir %b exp 0/0", exc_misalign, redirect_valid); end
   endtask

   task automatic test_reset_mid;
      alu_wb_rd_wr_en = 1'b1; alu_wb_rd_addr = 5'd1; alu_wb_data = 32'h9;
      for (int k = 0; k < 3; k++) begin
         lsu_wb_valid = 1'b1; lsu_wb_rd_addr = 5'(12 + k); lsu_wb_data = 32'hC0 + k;
         tick();
      end
      n_checks++; if (lq_count !== 3'd3) begin n_fail++; $display("FAIL mid_count_pre got %0d exp 3", lq_count); end
      idle_inputs();
      rst_n = 1'b0;
      tick();
      n_checks++; if (lq_count !== 3'd0 || rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd0 || rf_wr_data !== 32'd0) begin
         n_fail++; $display("FAIL mid_reset got cnt %0d en %b addr %0d data %h exp 0", lq_count, rf_wr_en, rf_wr_addr, rf_wr_data); end
      n_checks++; if (redirect_pc !== 32'd0 || exc_tval !== 32'd0 || lsu_wb_ready !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_regs got pc %h tval %h rdy %b exp 0/0/0", redirect_pc, exc_tval, lsu_wb_ready); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (lsu_wb_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready got %b exp 1", lsu_wb_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (rf_wr_en !== 1'b0 || lq_count !== 3'd0) begin
            n_fail++; $display("FAIL mid_no_write[%0d] got en %b cnt %0d exp 0/0", k, rf_wr_en, lq_count); end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_fill_drain();
      test_waw_squash();
      test_same_cycle_kill();
      test_rd0_push();
      test_push_pop();
      test_redirect();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wb_ctrl.md
# wb_ctrl

Writeback controller sitting directly downstream of the ALU. Merges the ALU's registered writeback (`alu_wb_*`) and load results from the LSU onto the single register-file write port, and turns the ALU's `pc_out`/`pc_load` into a one-cycle fetch redirect or a misaligned-target exception. LSU results are buffered in a small FIFO because the ALU has strict priority and cannot be stalled.

## Interface
- `XLEN`, 32, datapath width
- `LQ_DEPTH`, 4, LSU result FIFO entries, power of two, ≥2
- `clk` input 1: clock, all state on rising edge
- `rst_n` input 1: reset, synchronous, active-low
- `alu_wb_data` input XLEN: ALU result
- `alu_wb_rd_addr` input 5: ALU destination register
- `alu_wb_rd_wr_en` input 1: ALU write request
- `alu_pc_out` input XLEN: branch/jump target
- `alu_pc_load` input 1: target valid this cycle
- `lsu_wb_valid` input 1: LSU result offered
- `lsu_wb_ready` output 1: FIFO can accept
- `lsu_wb_data` input XLEN: load data
- `lsu_wb_rd_addr` input 5: load destination
- `rf_wr_en` output 1: register-file write strobe, registered
- `rf_wr_addr` output 5: registered write address
- `rf_wr_data` output XLEN: registered write data
- `redirect_valid` output 1: one-cycle fetch redirect pulse
- `redirect_pc` output XLEN: redirect target
- `exc_misalign` output 1: one-cycle misaligned-target pulse
- `exc_tval` output XLEN: faulting target
- `lq_count` output $clog2(LQ_DEPTH)+1: FIFO occupancy

## Operation
- Push: on `lsu_wb_valid & lsu_wb_ready`. If `lsu_wb_rd_addr == 0`, accept but do not enqueue.
- `lsu_wb_ready = rst_n & (lq_count != LQ_DEPTH)`. Push and pop in the same cycle while full is not allowed; ready is based on the current count only.
- ALU write is effective when `alu_wb_rd_wr_en & (alu_wb_rd_addr != 0)`. An effective ALU write always owns the port this cycle.
- Drain: if there is no effective ALU write and the FIFO is non-empty, pop the head. If the head's kill bit is clear, write its data; if set, pop with no write (`rf_wr_en = 0`).
- WAW squash:
  - An effective ALU write sets the kill bit of every FIFO entry, present at the start of that cycle, whose rd matches `alu_wb_rd_addr`.
  - An entry being pushed in the same cycle is not killed.
- Redirect, when `alu_pc_load`:
  - If `alu_pc_out[1:0] == 0`: `redirect_valid = 1` and `redirect_pc = alu_pc_out` next cycle.
  - Otherwise: `exc_misalign = 1` and `exc_tval = alu_pc_out` next cycle; `redirect_valid` stays 0.
- Redirect does not flush the FIFO and does not affect writes; all queued results are older.
- Pointers are `$clog2(LQ_DEPTH)` bits and wrap modulo `LQ_DEPTH`. The count tracks push minus pop.

## Timing
- Reset (`rst_n` low at an edge):
  - Pointers, count and kill bits go to 0.
  - `rf_wr_en`, `redirect_valid`, `exc_misalign` go to 0.
  - `rf_wr_addr`, `rf_wr_data`, `redirect_pc`, `exc_tval` go to 0.
  - `lsu_wb_ready` is 0 while `rst_n` is low.
- Reset mid-operation discards all queued entries; no write is issued for them.
- ALU path latency: 1 cycle. ALU inputs at edge N appear on `rf_*` after edge N+1.
- LSU path latency: at least 2 cycles (push at N, earliest pop at N+1, `rf_*` valid after N+2). Each cycle with an effective ALU write adds one cycle of delay.
- Redirect and exception latency: 1 cycle. Back-to-back `alu_pc_load` gives back-to-back pulses.
- Simultaneous push and pop when not full: count unchanged; the new entry goes behind the head.
- Empty FIFO with no ALU write: `rf_wr_en = 0`.

## Test plan
- ALU only: `alu_wb_rd_wr_en = 1`, rd=5, data=0xDEADBEEF, one cycle → one cycle later `rf_wr_en = 1`, addr 5, data 0xDEADBEEF. A following request with rd=0 → `rf_wr_en = 0`.
- LSU fill and drain, LQ_DEPTH=4:
  - Hold ALU writes active (rd=1) and push loads to rd 2,3,4,6 → `lsu_wb_ready` drops to 0 after 4 pushes, `lq_count = 4`.
  - Release the ALU → writes to rd 2,3,4,6 in order on 4 consecutive cycles; ready returns to 1 after the first pop.
- WAW squash: queue a load to rd=7 (data 0x11) while the ALU is busy; then ALU writes rd=7 (data 0x22) → only one write to rd 7, data 0x22; the load entry pops with no write.
- Same-cycle kill exclusion: ALU writes rd=8 in the same cycle the LSU pushes rd=8 (data 0x33) → ALU write first; the load write of 0x33 follows in a later cycle.
- Redirect:
  - `alu_pc_load` with target 0x1000 → `redirect_valid` pulse, `redirect_pc = 0x1000`.
  - Target 0x1002 → `exc_misalign` pulse, `exc_tval = 0x1002`, no redirect.
- Reset mid-drain: 3 entries queued, `rst_n` low for one edge → `lq_count = 0`, all outputs 0, no further `rf_wr_en`, `lsu_wb_ready = 1` on the first cycle after reset release.
